// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame buffer: FSM states, colour
// channel slots within the {G,R,B} pixel word, and an address-width helper.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Channel slot index; the field LSB is slot * COLOR_W.
  localparam int G_SLOT = 2;
  localparam int R_SLOT = 1;
  localparam int B_SLOT = 0;

  function automatic int addr_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/ws2812_frame_buf_if.sv
// Host/serialiser bundle of the WS2812 frame buffer.
// The bright signal exists only when WS_BRIGHT_EN is defined.
interface ws2812_frame_buf_if
  import ws2812_pkg::*;
#(
  parameter int PIXELS  = 64,
  parameter int FRAMES  = 4,
  parameter int COLOR_W = 8
);
  localparam int FW = addr_w(FRAMES);
  localparam int AW = addr_w(PIXELS);
  localparam int DW = 3 * COLOR_W;

  logic          wr_en;
  logic [FW-1:0] wr_frame;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [FW-1:0] disp_frame;
  logic          auto_mode;
  logic          start;
`ifdef WS_BRIGHT_EN
  logic [COLOR_W-1:0] bright;
`endif
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          frame_done;
  logic          busy;
  logic [FW-1:0] cur_frame;

  modport master (
`ifdef WS_BRIGHT_EN
    output bright,
`endif
    output wr_en, wr_frame, wr_addr, wr_data, disp_frame, auto_mode, start, pix_ready,
    input  pix_data, pix_valid, frame_done, busy, cur_frame
  );

  modport slave (
`ifdef WS_BRIGHT_EN
    input  bright,
`endif
    input  wr_en, wr_frame, wr_addr, wr_data, disp_frame, auto_mode, start, pix_ready,
    output pix_data, pix_valid, frame_done, busy, cur_frame
  );

endinterface

// File: rtl/ws2812_pix_ram.sv
// Simple dual-port pixel RAM, read-first; the read register is reset to zero
// so pix_data is cleared by reset even though the array is not.
module ws2812_pix_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 24,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Nonblocking update of r_mem makes a same-edge read return the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ws2812_frame_buf.sv
// Multi-frame WS2812 pixel store and frame readout sequencer.
// Optional WS_BRIGHT_EN adds a registered global-brightness scaling stage.
module ws2812_frame_buf
  import ws2812_pkg::*;
#(
  parameter int PIXELS      = 64,
  parameter int FRAMES      = 4,
  parameter int COLOR_W     = 8,
  parameter int HOLD_FRAMES = 16
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  ws2812_frame_buf_if.slave bus
);

  localparam int FW  = addr_w(FRAMES);
  localparam int AW  = addr_w(PIXELS);
  localparam int DW  = 3 * COLOR_W;
  localparam int RD  = FRAMES * PIXELS;
  localparam int RAW = addr_w(RD);
  localparam int HW  = addr_w(HOLD_FRAMES);

  localparam logic [FW-1:0] FRAME_MAX = FW'(FRAMES - 1);
  localparam logic [AW-1:0] LAST_PIX  = AW'(PIXELS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  state_t         r_state;
  state_t         w_next;
  logic [FW-1:0]  r_frame;
  logic [AW-1:0]  r_addr;
  logic [FW-1:0]  r_auto_frame;
  logic [HW-1:0]  r_refresh;
  logic           r_valid;
  logic           r_done;
  logic           r_busy;
  logic [FW-1:0]  w_sel_frame;
  logic           w_frame_ok;
  logic           w_pix_ok;
  logic           w_hs;
  logic           w_rd_en;
  logic           w_rd_last;
  logic [RAW-1:0] w_rd_addr;
  logic [RAW-1:0] w_wr_addr;
  logic [DW-1:0]  w_ram_q;

  // Range checks only exist when the index field can encode illegal values.
  generate
    if ((1 << FW) > FRAMES) begin : g_frame_chk
      assign w_sel_frame = (bus.disp_frame > FRAME_MAX) ? FRAME_MAX : bus.disp_frame;
      assign w_frame_ok  = (bus.wr_frame <= FRAME_MAX);
    end else begin : g_frame_full
      assign w_sel_frame = bus.disp_frame;
      assign w_frame_ok  = 1'b1;
    end
    if ((1 << AW) > PIXELS) begin : g_pix_chk
      assign w_pix_ok = (bus.wr_addr <= LAST_PIX);
    end else begin : g_pix_full
      assign w_pix_ok = 1'b1;
    end
  endgenerate

  assign w_hs      = (r_state == ST_PRESENT) && bus.pix_ready;
  assign w_rd_addr = RAW'(r_frame) * RAW'(PIXELS) + RAW'(r_addr);
  assign w_wr_addr = RAW'(bus.wr_frame) * RAW'(PIXELS) + RAW'(bus.wr_addr);

  ws2812_pix_ram #(.DEPTH(RD), .DW(DW), .AW(RAW)) u_ram (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .i_wr_en   (bus.wr_en && w_frame_ok && w_pix_ok),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

`ifdef WS_BRIGHT_EN
  logic          r_phase;
  logic [DW-1:0] r_scaled;

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] w, input logic [COLOR_W-1:0] b);
    logic [DW-1:0]        res;
    logic [2*COLOR_W-1:0] prod;
    res = '0;
    for (int s = 0; s < 3; s++) begin
      prod = {{COLOR_W{1'b0}}, w[s*COLOR_W +: COLOR_W]} * {{COLOR_W{1'b0}}, b};
      res[s*COLOR_W +: COLOR_W] = prod[2*COLOR_W-1:COLOR_W];
    end
    return res;
  endfunction

  // READ spans two cycles here: RAM access, then the scaling register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_phase  <= 1'b0;
      r_scaled <= '0;
    end else begin
      r_phase <= (r_state == ST_READ) ? ~r_phase : 1'b0;
      if ((r_state == ST_READ) && r_phase) begin
        r_scaled <= scale(w_ram_q, bus.bright);
      end
    end
  end

  assign w_rd_en       = (r_state == ST_READ) && !r_phase;
  assign w_rd_last     = r_phase;
  assign bus.pix_data  = r_scaled;
`else
  assign w_rd_en       = (r_state == ST_READ);
  assign w_rd_last     = 1'b1;
  assign bus.pix_data  = w_ram_q;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next = ST_READ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_READ: begin
        if (w_rd_last) begin
          w_next = ST_PRESENT;
        end else begin
          w_next = ST_READ;
        end
      end
      ST_PRESENT: begin
        if (!w_hs) begin
          w_next = ST_PRESENT;
        end else if (r_addr == LAST_PIX) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_READ;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame      <= '0;
      r_addr       <= '0;
      r_auto_frame <= '0;
      r_refresh    <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == ST_PRESENT);
      r_done  <= (w_next == ST_DONE);
      r_busy  <= (w_next != ST_IDLE);
      if ((r_state == ST_IDLE) && bus.start) begin
        r_frame <= bus.auto_mode ? r_auto_frame : w_sel_frame;
        r_addr  <= '0;
      end else if (w_hs && (r_addr != LAST_PIX)) begin
        r_addr <= r_addr + AW'(1);
      end
      if ((r_state == ST_DONE) && bus.auto_mode) begin
        if (r_refresh == HOLD_LAST) begin
          r_refresh    <= '0;
          r_auto_frame <= (r_auto_frame == FRAME_MAX) ? '0 : r_auto_frame + FW'(1);
        end else begin
          r_refresh <= r_refresh + HW'(1);
        end
      end
    end
  end

  assign bus.pix_valid  = r_valid;
  assign bus.frame_done = r_done;
  assign bus.busy       = r_busy;
  assign bus.cur_frame  = r_frame;

endmodule

// File: tb/tb_ws2812_frame_buf.sv
// Directed bench for ws2812_frame_buf: table of frame readouts plus hand
// sequences for write-during-read, out-of-range write and mid-frame reset.
module tb_ws2812_frame_buf;

  localparam int PIX  = 64;
  localparam int FRM  = 3;
  localparam int HOLD = 2;
`ifdef WS_BRIGHT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  logic [23:0] model [FRM][PIX];

  ws2812_frame_buf_if #(.PIXELS(PIX), .FRAMES(FRM), .COLOR_W(8)) bus ();

  ws2812_frame_buf #(.PIXELS(PIX), .FRAMES(FRM), .COLOR_W(8), .HOLD_FRAMES(HOLD)) u_dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       auto_m;
    logic [1:0] disp;
    logic [1:0] exp_frame;
    int         stall_pix;
    int         wr_pix;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input logic [23:0] w);
`ifdef WS_BRIGHT_EN
    int g, r, b;
    g = (int'(w[23:16]) * 128) / 256;
    r = (int'(w[15:8])  * 128) / 256;
    b = (int'(w[7:0])   * 128) / 256;
    return {g[7:0], r[7:0], b[7:0]};
`else
    return w;
`endif
  endfunction

  task automatic run_frame(input logic am, input logic [1:0] disp, input logic [1:0] fexp,
                           input int stall_pix, input int wr_pix);
    int wc;
    bus.auto_mode  = am;
    bus.disp_frame = disp;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check("cur_frame", 32'(bus.cur_frame), 32'(fexp));
    check("busy_on", 32'(bus.busy), 32'd1);
    for (int k = 0; k < PIX; k++) begin
      wc = 1;
      if (k == wr_pix) begin
        bus.wr_en    = 1'b1;
        bus.wr_frame = fexp;
        bus.wr_addr  = k[5:0];
        bus.wr_data  = 24'hABCDEF;
        tick();
        bus.wr_en = 1'b0;
        wc = 2;
      end
      while (!bus.pix_valid && wc < 20) begin
        tick();
        wc++;
      end
      check("latency", 32'(wc), 32'(LAT));
      check("pix_data", 32'(bus.pix_data), 32'(exp_pix(model[fexp][k])));
      if (k == stall_pix) begin
        bus.pix_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick();
          check("stall_valid", 32'(bus.pix_valid), 32'd1);
          check("stall_data", 32'(bus.pix_data), 32'(exp_pix(model[fexp][k])));
        end
        bus.pix_ready = 1'b1;
      end
      if (k == wr_pix) model[fexp][k] = 24'hABCDEF;
      tick();
      check("valid_drop", 32'(bus.pix_valid), 32'd0);
      if (k < PIX - 1) check("no_early_done", 32'(bus.frame_done), 32'd0);
    end
    check("frame_done", 32'(bus.frame_done), 32'd1);
    tick();
    check("done_pulse", 32'(bus.frame_done), 32'd0);
    check("busy_off", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[13];
    int   guard;
    n_chk = 0;
    n_err = 0;

    vecs[0]  = '{1'b0, 2'd1, 2'd1, 5, -1};
    vecs[1]  = '{1'b1, 2'd0, 2'd0, -1, -1};
    vecs[2]  = '{1'b1, 2'd0, 2'd0, -1, -1};
    vecs[3]  = '{1'b1, 2'd0, 2'd1, -1, -1};
    vecs[4]  = '{1'b1, 2'd0, 2'd1, -1, -1};
    vecs[5]  = '{1'b1, 2'd0, 2'd2, -1, -1};
    vecs[6]  = '{1'b1, 2'd0, 2'd2, -1, -1};
    vecs[7]  = '{1'b1, 2'd1, 2'd0, -1, -1};
    vecs[8]  = '{1'b0, 2'd1, 2'd1, -1, 7};
    vecs[9]  = '{1'b0, 2'd3, 2'd2, -1, -1};
    vecs[10] = '{1'b0, 2'd1, 2'd1, -1, -1};
    vecs[11] = '{1'b1, 2'd2, 2'd0, -1, -1};
    vecs[12] = '{1'b1, 2'd0, 2'd1, -1, -1};

    rst_n          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_frame   = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.disp_frame = '0;
    bus.auto_mode  = 1'b0;
    bus.start      = 1'b0;
    bus.pix_ready  = 1'b1;
`ifdef WS_BRIGHT_EN
    bus.bright     = 8'h80;
`endif
    tick();
    tick();
    check("rst_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_data", 32'(bus.pix_data), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cur_frame", 32'(bus.cur_frame), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int f = 0; f < FRM; f++) begin
      for (int k = 0; k < PIX; k++) begin
        if (f == 0) model[f][k] = (k == 0) ? 24'h80FF40 : (24'h100000 | 24'(k));
        else if (f == 1) model[f][k] = 24'(k);
        else model[f][k] = 24'h200000 | 24'(k);
        bus.wr_en    = 1'b1;
        bus.wr_frame = f[1:0];
        bus.wr_addr  = k[5:0];
        bus.wr_data  = model[f][k];
        tick();
      end
    end
    bus.wr_frame = 2'd3;
    bus.wr_addr  = 6'd5;
    bus.wr_data  = 24'h555555;
    tick();
    bus.wr_en = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      run_frame(vecs[i].auto_m, vecs[i].disp, vecs[i].exp_frame, vecs[i].stall_pix, vecs[i].wr_pix);
    end

    bus.auto_mode  = 1'b0;
    bus.disp_frame = 2'd1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    guard = 0;
    while (!(bus.pix_valid && bus.pix_data == exp_pix(model[1][20])) && guard < 500) begin
      tick();
      guard++;
    end
    check("reach_pix20", 32'(guard < 500), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.pix_valid), 32'd0);
    check("arst_data", 32'(bus.pix_data), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_cur_frame", 32'(bus.cur_frame), 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("arst_no_done", 32'(bus.frame_done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    run_frame(1'b0, 2'd1, 2'd1, -1, -1);
    run_frame(1'b1, 2'd2, 2'd0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
